// File: rtl/mmio_regfile_gen2.sv
`default_nettype none
// ============================================================================
// Module   : mmio_regfile_gen2
// Purpose  : Parametrised memory-mapped register file between the CPU
//            register port and the peripherals. It provides:
//              - NUM_RW read/write registers at 0..NUM_RW-1
//              - a read-only status window at RO_BASE..RO_BASE+NUM_RO-1
//              - self-clearing pulse registers (PULSE_MASK)
//              - atomic low/high register pairs through a shadow (PAIR_MASK)
//              - a sticky write-1-to-clear interrupt status register at
//                IRQ_ADDR, with an enable mask at IRQ_EN_ADDR and a
//                registered IRQ output
// Ports    : clk, rst         - clock, synchronous active-high reset
//            w_enable/w_addr/w_data - write port (committed at clk edge)
//            r_addr_a/r_data_a, r_addr_b/r_data_b - combinational reads
//            regs_out          - flat committed RW contents, reg i at i*DATA_W
//            wr_strobe         - per-register pulse the cycle after commit
//            ro_in             - flat peripheral status inputs
//            irq_src           - level interrupt sources
//            irq_status        - sticky interrupt status
//            irq_out           - registered OR of enabled status bits
// Options  : define REGFILE_BYPASS_EN to forward a committing write onto
//            the read ports in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_regfile_gen2 #(
    parameter int          DATA_W      = 8,
    parameter int          ADDR_W      = 6,
    parameter int          NUM_RW      = 32,
    parameter int          NUM_RO      = 8,
    parameter int          RO_BASE     = 32,
    parameter logic [31:0] PULSE_MASK  = 32'h0,
    parameter logic [31:0] PAIR_MASK   = 32'h0,
    parameter int          NUM_IRQ     = 8,
    parameter int          IRQ_ADDR    = 40,
    parameter int          IRQ_EN_ADDR = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_enable,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [ADDR_W-1:0]        r_addr_a,
    input  logic [ADDR_W-1:0]        r_addr_b,
    output logic [DATA_W-1:0]        r_data_a,
    output logic [DATA_W-1:0]        r_data_b,
    output logic [NUM_RW*DATA_W-1:0] regs_out,
    output logic [NUM_RW-1:0]        wr_strobe,
    input  logic [NUM_RO*DATA_W-1:0] ro_in,
    input  logic [NUM_IRQ-1:0]       irq_src,
    output logic [NUM_IRQ-1:0]       irq_status,
    output logic                     irq_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_regs   [NUM_RW];
    logic [DATA_W-1:0]  r_shadow [NUM_RW];  // only pair-low entries are ever written
    logic [NUM_RW-1:0]  r_strobe;
    logic [NUM_IRQ-1:0] r_irq_status;
    logic               r_irq_out;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic [NUM_RW-1:0]  w_hit;        // write strobe addresses register i directly
    logic [NUM_RW-1:0]  w_commit;     // register i takes a new value at this edge
    logic [NUM_RW-1:0]  w_shadow_we;  // pair-low write lands in the shadow only
    logic [DATA_W-1:0]  w_commit_val [NUM_RW];
    logic [NUM_IRQ-1:0] w_irq_clr;

    for (genvar i = 0; i < NUM_RW; i++) begin : g_dec
        // A register that is the high half of a pair is never treated as a
        // low half itself, so overlapping masks degrade to plain pairs.
        localparam bit c_HIGH = (i > 0) && PAIR_MASK[(i > 0) ? i - 1 : 0];
        localparam bit c_LOW  = PAIR_MASK[i] && !c_HIGH;

        assign w_hit[i] = w_enable && (w_addr == ADDR_W'(i));

        if (c_LOW) begin : g_low
            // The low half only changes when its high partner is written.
            assign w_commit[i]     = w_hit[i+1];
            assign w_shadow_we[i]  = w_hit[i];
            assign w_commit_val[i] = r_shadow[i];
        end else begin : g_plain
            assign w_commit[i]     = w_hit[i];
            assign w_shadow_we[i]  = 1'b0;
            assign w_commit_val[i] = w_data;
        end
    end

    assign w_irq_clr = (w_enable && (w_addr == ADDR_W'(IRQ_ADDR)))
                       ? w_data[NUM_IRQ-1:0] : '0;

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_regs[i]   <= '0;
                r_shadow[i] <= '0;
            end
            r_strobe     <= '0;
            r_irq_status <= '0;
            r_irq_out    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                // A fresh write beats the self-clear, which is what lets
                // back-to-back pulse writes hold for another cycle.
                if (w_commit[i]) begin
                    r_regs[i] <= w_commit_val[i];
                end else if (PULSE_MASK[i]) begin
                    r_regs[i] <= '0;
                end
                if (w_shadow_we[i]) begin
                    r_shadow[i] <= w_data;
                end
            end
            r_strobe     <= w_commit;
            // Sources are OR-ed in after the clear so a same-cycle set wins.
            r_irq_status <= (r_irq_status & ~w_irq_clr) | irq_src;
            r_irq_out    <= |(r_irq_status & r_regs[IRQ_EN_ADDR][NUM_IRQ-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux (shared by both ports)
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (addr == ADDR_W'(i)) begin
`ifdef REGFILE_BYPASS_EN
                // w_commit_val is w_data for a direct write and the shadow
                // for the low half of a committing pair.
                v = w_commit[i] ? w_commit_val[i] : r_regs[i];
`else
                v = r_regs[i];
`endif
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (addr == ADDR_W'(RO_BASE + j)) begin
                v = ro_in[j*DATA_W +: DATA_W];
            end
        end
        if (addr == ADDR_W'(IRQ_ADDR)) begin
            v = DATA_W'(r_irq_status);
        end
        return v;
    endfunction

    assign r_data_a = read_word(r_addr_a);
    assign r_data_b = read_word(r_addr_b);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RW; i++) begin : g_out
        assign regs_out[i*DATA_W +: DATA_W] = r_regs[i];
    end

    assign wr_strobe  = r_strobe;
    assign irq_status = r_irq_status;
    assign irq_out    = r_irq_out;

endmodule
`default_nettype wire

// File: tb/tb_mmio_regfile_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_regfile_gen2
// Purpose  : Self-checking bench for mmio_regfile_gen2 configured with a
//            pulse register at 5 and a pair at 8/9. Directed table vectors,
//            hand-written multi-cycle sequences and a randomized phase
//            against a behavioural model of the register map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_regfile_gen2;

    localparam int DW  = 8;
    localparam int AW  = 6;
    localparam int NRW = 32;
    localparam int NRO = 8;
    localparam int NIQ = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              w_enable;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic [AW-1:0]     r_addr_a;
    logic [AW-1:0]     r_addr_b;
    logic [DW-1:0]     r_data_a;
    logic [DW-1:0]     r_data_b;
    logic [NRW*DW-1:0] regs_out;
    logic [NRW-1:0]    wr_strobe;
    logic [NRO*DW-1:0] ro_in;
    logic [NIQ-1:0]    irq_src;
    logic [NIQ-1:0]    irq_status;
    logic              irq_out;

    mmio_regfile_gen2 #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .NUM_RW     (NRW),
        .NUM_RO     (NRO),
        .RO_BASE    (32),
        .PULSE_MASK (32'h0000_0020),
        .PAIR_MASK  (32'h0000_0100),
        .NUM_IRQ    (NIQ),
        .IRQ_ADDR   (40),
        .IRQ_EN_ADDR(31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_enable  (w_enable),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .r_addr_a  (r_addr_a),
        .r_addr_b  (r_addr_b),
        .r_data_a  (r_data_a),
        .r_data_b  (r_data_b),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .ro_in     (ro_in),
        .irq_src   (irq_src),
        .irq_status(irq_status),
        .irq_out   (irq_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // Behavioural model of the register map
    // ------------------------------------------------------------------
    logic [7:0]  m_regs [32];
    logic [7:0]  m_shadow;
    logic [7:0]  m_status;
    logic [31:0] m_strobe;
    logic        m_irq_out;

    task automatic model_step();
        int a;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
            m_shadow  = 8'h00;
            m_status  = 8'h00;
            m_strobe  = 32'h0;
            m_irq_out = 1'b0;
        end else begin
            a = int'(w_addr);
            m_irq_out = (m_status & m_regs[31]) != 8'h00;
            m_status  = (m_status & ~((w_enable && a == 40) ? w_data : 8'h00)) | irq_src;
            m_strobe  = 32'h0;
            m_regs[5] = 8'h00;
            if (w_enable && a < 32) begin
                if (a == 8) begin
                    m_shadow = w_data;
                end else if (a == 9) begin
                    m_regs[8]   = m_shadow;
                    m_regs[9]   = w_data;
                    m_strobe[8] = 1'b1;
                    m_strobe[9] = 1'b1;
                end else begin
                    m_regs[a]   = w_data;
                    m_strobe[a] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [7:0] m_read(input logic [5:0] addr);
        int a;
        logic [7:0] v;
        a = int'(addr);
        if (a < 32)       v = m_regs[a];
        else if (a < 40)  v = ro_in[(a-32)*8 +: 8];
        else if (a == 40) v = m_status;
        else              v = 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (w_enable && int'(w_addr) < 32 && int'(w_addr) != 8) begin
            if (addr == w_addr)                  v = w_data;
            else if (int'(w_addr) == 9 && a == 8) v = m_shadow;
        end
`endif
        return v;
    endfunction

    function automatic logic [255:0] m_flat();
        logic [255:0] f;
        for (int i = 0; i < 32; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] pick_addr();
        case ($urandom_range(0, 7))
            3:       return 6'd5;
            4:       return 6'd8;
            5:       return 6'd9;
            6:       return 6'd31;
            7:       return 6'd40;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Directed vectors: inputs for one edge and the values expected after it
    // ------------------------------------------------------------------
    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
        logic [7:0] src;
        logic [7:0] e_r5;
        logic [7:0] e_r8;
        logic [7:0] e_r9;
        logic [1:0] e_stb;   // {wr_strobe[9], wr_strobe[8]}
        logic [7:0] e_st;
        logic       e_irq;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    initial begin
        logic [7:0] exp_a;
        logic [7:0] exp_b;

        vecs[0]  = '{1'b1, 6'd5,  8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 6'd5,  8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 6'd5,  8'h3C, 8'h00, 8'h3C, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 6'd8,  8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 6'd9,  8'h12, 8'h00, 8'h00, 8'h34, 8'h12, 2'b11, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 2'b00, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 6'd31, 8'h04, 8'h00, 8'h00, 8'h34, 8'h12, 2'b00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 6'd0,  8'h00, 8'h04, 8'h00, 8'h34, 8'h12, 2'b00, 8'h04, 1'b0};
        vecs[10] = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 2'b00, 8'h04, 1'b1};
        vecs[11] = '{1'b1, 6'd40, 8'h04, 8'h00, 8'h00, 8'h34, 8'h12, 2'b00, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 6'd0,  8'h00, 8'h04, 8'h00, 8'h34, 8'h12, 2'b00, 8'h04, 1'b0};
        vecs[13] = '{1'b1, 6'd40, 8'h04, 8'h04, 8'h00, 8'h34, 8'h12, 2'b00, 8'h04, 1'b1};
        vecs[14] = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 2'b00, 8'h04, 1'b1};
        vecs[15] = '{1'b1, 6'd40, 8'hFF, 8'h00, 8'h00, 8'h34, 8'h12, 2'b00, 8'h00, 1'b1};
        vecs[16] = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 2'b00, 8'h00, 1'b0};

        rst      = 1'b1;
        w_enable = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        r_addr_a = '0;
        r_addr_b = '0;
        irq_src  = '0;
        ro_in    = {$urandom, $urandom};

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_regs_out",   regs_out,   256'h0);
        check("rst_wr_strobe",  wr_strobe,  256'h0);
        check("rst_irq_status", irq_status, 256'h0);
        check("rst_irq_out",    irq_out,    256'h0);
        rst = 1'b0;

        // ---------------- read sweep of the whole map ----------------
        for (int a = 0; a < 64; a++) begin
            r_addr_a = 6'(a);
            r_addr_b = 6'(63 - a);
            #1;
            exp_a = (a >= 32 && a < 40) ? ro_in[(a-32)*8 +: 8] : 8'h00;
            exp_b = ((63 - a) >= 32 && (63 - a) < 40) ? ro_in[(31-a)*8 +: 8] : 8'h00;
            check($sformatf("sweep_a%0d", a), r_data_a, exp_a);
            check($sformatf("sweep_b%0d", 63 - a), r_data_b, exp_b);
            tick();
        end

        // ---------------- write into RO window is ignored ----------------
        w_enable = 1'b1;
        w_addr   = 6'd35;
        w_data   = 8'hFF;
        tick();
        w_enable = 1'b0;
        r_addr_a = 6'd35;
        #1;
        check("ro_write_regs",   regs_out,  256'h0);
        check("ro_write_strobe", wr_strobe, 256'h0);
        check("ro_write_read",   r_data_a,  ro_in[3*8 +: 8]);

        // ---------------- table vectors ----------------
        for (int k = 0; k < NVEC; k++) begin
            w_enable = vecs[k].we;
            w_addr   = vecs[k].addr;
            w_data   = vecs[k].data;
            irq_src  = vecs[k].src;
            tick();
            w_enable = 1'b0;
            irq_src  = '0;
            check($sformatf("tbl%0d_reg5", k), regs_out[5*8 +: 8], vecs[k].e_r5);
            check($sformatf("tbl%0d_reg8", k), regs_out[8*8 +: 8], vecs[k].e_r8);
            check($sformatf("tbl%0d_reg9", k), regs_out[9*8 +: 8], vecs[k].e_r9);
            check($sformatf("tbl%0d_stb", k),  {wr_strobe[9], wr_strobe[8]}, vecs[k].e_stb);
            check($sformatf("tbl%0d_stat", k), irq_status, vecs[k].e_st);
            check($sformatf("tbl%0d_irq", k),  irq_out, vecs[k].e_irq);
        end

        // ---------------- reset between pair low and high ----------------
        w_enable = 1'b1;
        w_addr   = 6'd8;
        w_data   = 8'h55;
        tick();
        w_enable = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        w_enable = 1'b1;
        w_addr   = 6'd9;
        w_data   = 8'h77;
        tick();
        w_enable = 1'b0;
        check("midrst_reg8", regs_out[8*8 +: 8], 8'h00);
        check("midrst_reg9", regs_out[9*8 +: 8], 8'h77);
        check("midrst_stb",  {wr_strobe[9], wr_strobe[8]}, 2'b11);

        // ---------------- same-cycle read of a committing write ----------------
        w_enable = 1'b1;
        w_addr   = 6'd3;
        w_data   = 8'h11;
        tick();
        w_data   = 8'h5A;
        r_addr_a = 6'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_reg3", r_data_a, 8'h5A);
`else
        check("bypass_reg3", r_data_a, 8'h11);
`endif
        tick();
        w_addr = 6'd8;
        w_data = 8'hC3;
        r_addr_a = 6'd8;
        #1;
        check("bypass_pairlow_nofwd", r_data_a, 8'h00);
        tick();
        w_addr   = 6'd9;
        w_data   = 8'hE1;
        r_addr_b = 6'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_pair8", r_data_a, 8'hC3);
        check("bypass_pair9", r_data_b, 8'hE1);
`else
        check("bypass_pair8", r_data_a, 8'h00);
        check("bypass_pair9", r_data_b, 8'h77);
`endif
        tick();
        w_enable = 1'b0;
        check("pair_commit8", regs_out[8*8 +: 8], 8'hC3);
        check("pair_commit9", regs_out[9*8 +: 8], 8'hE1);

        // ---------------- randomized phase against the model ----------------
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            w_enable = 1'($urandom_range(0, 1));
            w_addr   = pick_addr();
            w_data   = 8'($urandom);
            irq_src  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            r_addr_a = pick_addr();
            r_addr_b = pick_addr();
            if ($urandom_range(0, 15) == 0) ro_in = {$urandom, $urandom};
            #1;
            check($sformatf("rnd%0d_rda", c), r_data_a, m_read(r_addr_a));
            check($sformatf("rnd%0d_rdb", c), r_data_b, m_read(r_addr_b));
            tick();
            check($sformatf("rnd%0d_regs", c), regs_out,   m_flat());
            check($sformatf("rnd%0d_stb", c),  wr_strobe,  m_strobe);
            check($sformatf("rnd%0d_stat", c), irq_status, m_status);
            check($sformatf("rnd%0d_irq", c),  irq_out,    m_irq_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_regfile_gen2.md
Name: mmio_regfile_gen2

Overview:
Parametrised memory-mapped register file that sits between the CPU register port and the peripherals (RAM address, random, LEDs, timer, framebuffer, LCD). It generalises the fixed 40-entry file in five ways: configurable width and depth, a read-only status window, self-clearing pulse registers, atomic 16-bit register pairs, and a sticky write-1-to-clear interrupt status register with enable-masked IRQ output.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 6, address width
NUM_RW, 32, writable registers at addresses 0..NUM_RW-1
NUM_RO, 8, read-only status registers at addresses RO_BASE..RO_BASE+NUM_RO-1
RO_BASE, 32, first read-only address; must be >= NUM_RW
PULSE_MASK, 32'h0, bit i=1: RW register i self-clears one cycle after a write
PAIR_MASK, 32'h0, bit i=1: registers i and i+1 form an atomic pair (i low, i+1 high); bit NUM_RW-1 must be 0
NUM_IRQ, 8, interrupt sources (<= DATA_W)
IRQ_ADDR, 40, address of the W1C interrupt status register; lies outside both windows
IRQ_EN_ADDR, 31, RW register holding the interrupt enable mask

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
w_enable  in  1  write strobe
w_addr  in  ADDR_W  write address
w_data  in  DATA_W  write data
r_addr_a  in  ADDR_W  read address A
r_addr_b  in  ADDR_W  read address B
r_data_a  out  DATA_W  read data A (combinational)
r_data_b  out  DATA_W  read data B (combinational)
regs_out  out  NUM_RW*DATA_W  flat committed RW register contents; register i at [i*DATA_W +: DATA_W]
wr_strobe  out  NUM_RW  one-cycle pulse per register, asserted the cycle after it is committed
ro_in  in  NUM_RO*DATA_W  flat peripheral status inputs
irq_src  in  NUM_IRQ  level interrupt sources, sampled every cycle
irq_status  out  NUM_IRQ  sticky interrupt status
irq_out  out  1  OR of (irq_status & enable bits)

Behaviour:
- Reset: all RW registers, the pair shadows, irq_status, wr_strobe and irq_out are 0.
- Reads are combinational:
  - Address < NUM_RW returns the committed value.
  - RO window returns the corresponding ro_in slice.
  - IRQ_ADDR returns irq_status zero-extended to DATA_W.
  - Any other address returns 0.
  - Both read ports are independent; identical addresses are legal.
- Writes take effect at the clk edge when w_enable=1. Writes to the RO window or to unmapped addresses are ignored.
- Pulse registers:
  - A written value is visible on regs_out for exactly one cycle, then returns to 0.
  - If the register is written again in the following cycle, the new value holds for another cycle.
- Pair low register (PAIR_MASK[i]=1):
  - A write goes only to the shadow; regs_out, reads and wr_strobe are unchanged.
  - A write to i+1 commits shadow->reg i and w_data->reg i+1 on the same edge, and asserts wr_strobe for both registers.
  - If the high register is written without a fresh low write, the existing shadow (last value, or 0 after reset) is committed again.
  - The shadow is not cleared on commit.
- irq_status update: next = (status & ~clr) | irq_src.
  - clr = w_data[NUM_IRQ-1:0] when the write targets IRQ_ADDR, else 0.
  - When a set and a clear hit the same bit in the same cycle, the set wins.
- irq_out is registered: it reflects status and enable one cycle after either changes.
- Reset asserted mid-sequence (for example after a pair low write) discards the shadow, and no commit occurs.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: if w_enable=1 and the read address equals w_addr of a committing RW write, the read port returns w_data in the same cycle.
  - Shadow-only pair-low writes are not forwarded.
  - For a pair-high write, reading the low address returns the shadow.
- Undefined: reads always return the pre-edge committed value.

Test Plan:
- Reset, then read every address 0..63 on both ports -> 0 everywhere except the RO window, which returns ro_in; write to address 35 -> no change anywhere.
- PULSE_MASK bit 5: write 8'hA5 to address 5 -> regs_out[5] = A5 for exactly one cycle, then 00; back-to-back writes of A5 then 3C -> A5, 3C, 00.
- PAIR_MASK bit 8: write 8'h34 to address 8 -> reg 8 is still 00; write 8'h12 to address 9 -> regs 8/9 become 34/12 on the same edge and wr_strobe[8] = wr_strobe[9] = 1 for one cycle.
- irq_src[2] pulses for 1 cycle -> irq_status = 04; with enable at address 31 = 04, irq_out = 1 one cycle later; write 04 to IRQ_ADDR -> status 00; W1C write while irq_src[2] = 1 -> bit stays 1.
- Write to address 8 (pair low), assert rst, then write address 9 = 8'h77 -> regs 8/9 = 00/77.
- Bypass build: write 8'h5A to address 3 while r_addr_a = 3 -> r_data_a = 5A in the same cycle; non-bypass build -> the old value.
